dmem_bus_ctrl: RTL and testbench

//  Data-memory access stage directly downstream of the single-cycle datapath. It takes the

---
 rtl/dmem_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_ctrl
// Description : Data-memory access stage placed after the single-cycle
//               datapath. It turns memread/memwrite plus a byte address
//               into a req/gnt/rvalid transaction on a wait-state data bus,
//               holds stall high until the access completes, and returns
//               registered load data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset             : clock (rising edge), async active-high reset
//   memread, memwrite      : access request from the controller
//   addr, wdata            : byte address and store data from the datapath
//   rdata                  : registered load data to the datapath
//   stall                  : freeze pc/regwrite while high (combinational)
//   err                    : faulted access (misaligned/timeout), DONE only
//   bus_req/we/addr/wdata  : bus request side
//   bus_gnt, bus_rvalid,
//   bus_rdata              : bus response side
// ============================================================================
module dmem_bus_ctrl #(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT     = 16,
  parameter int ALIGN_CHECK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             err,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_gnt,
  input  logic             bus_rvalid,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [WIDTH-1:0] bus_wdata_q, bus_wdata_d;

  logic acc;
  logic misaligned;
  logic timeout_hit;

  assign acc         = memread | memwrite;
  assign misaligned  = (ALIGN_CHECK != 0) && (addr[1:0] != 2'b00);
  // Counter starts at 0 in the first REQ cycle, so TIMEOUT-1 marks the
  // TIMEOUT-th cycle spent waiting on the bus.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (acc && misaligned) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          // Stores never disturb the load-data register, even when faulting.
          if (!memwrite) rdata_d = '0;
        end else if (acc) begin
          state_d     = S_REQ;
          bus_addr_d  = {addr[WIDTH-1:2], 2'b00};
          bus_wdata_d = wdata;
          bus_we_d    = memwrite;  // read+write together resolves to write
          cnt_d       = '0;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A write is complete on gnt; that wins over a coincident timeout.
        if (bus_gnt && bus_we_q) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!bus_we_q) rdata_d = '0;
        end else if (bus_gnt) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          state_d = S_DONE;
          rdata_d = bus_rdata;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: begin  // S_DONE: datapath commits this cycle
        state_d = S_IDLE;
      end
    endcase

    bus_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign stall     = acc & (state_q != S_DONE);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bus_ctrl
// Description : Self-checking bench for dmem_bus_ctrl. Each access is
//               described by when the bus grants / returns data; a
//               cycle-count model derives the stall length, request window,
//               error flag and load data, and a negedge process compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [31:0] addr, wdata, rdata;
  logic        stall, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  dmem_bus_ctrl #(.WIDTH(32), .TIMEOUT(TO), .ALIGN_CHECK(1)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_err, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  int          stall_cnt = 0;
  logic [6:0]  stall_hist = '0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    stall_hist <= {stall_hist[5:0], stall};
    if (stall === 1'b1) stall_cnt <= stall_cnt + 1;
    if (chk_en) begin
      chk("stall",   {31'd0, stall},   {31'd0, exp_stall});
      chk("bus_req", {31'd0, bus_req}, {31'd0, exp_req});
      chk("err",     {31'd0, err},     {31'd0, exp_err});
      chk("rdata",   rdata,            exp_rdata);
      if (exp_req) begin
        chk("bus_we",    {31'd0, bus_we}, {31'd0, exp_we});
        chk("bus_addr",  bus_addr,        exp_addr);
        chk("bus_wdata", bus_wdata,       exp_wdata);
      end
    end
  end

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      memread = 1'b0; memwrite = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      set_idle_exp();
    end
  endtask

  // One access. gnt_at / rv_at: index of the REQ / RESP cycle carrying
  // gnt / rvalid (-1 = never). Returns the number of stalled cycles seen.
  task automatic run_acc(input bit rd_en, input bit wr_en, input logic [31:0] a,
                         input logic [31:0] wd, input int gnt_at, input int rv_at,
                         input logic [31:0] rd, input bit junk_rv,
                         output int stalls_seen);
    bit is_wr, ferr;
    int nreq, nresp, len;
    is_wr = wr_en;
    ferr = 1'b0; nreq = 0; nresp = 0;
    if (a[1:0] != 2'b00) begin
      ferr = 1'b1;
    end else if (gnt_at >= 0 && gnt_at < TO) begin
      nreq = gnt_at + 1;
      if (!is_wr) begin
        if (rv_at >= 0 && rv_at < TO - nreq) nresp = rv_at + 1;
        else begin nresp = TO - nreq; ferr = 1'b1; end
      end
    end else begin
      nreq = TO; ferr = 1'b1;
    end
    len = 1 + nreq + nresp;

    for (int t = 0; t <= len; t++) begin
      @(posedge clk); #1;
      if (t == 0) stall_cnt = 0;
      memread = rd_en; memwrite = wr_en; addr = a; wdata = wd;
      bus_gnt = (gnt_at >= 0) && (t == 1 + gnt_at) && (t <= nreq);
      bus_rvalid = (!is_wr && rv_at >= 0 && nreq > 0 && t == 1 + nreq + rv_at)
                   || (junk_rv && t >= 1 && t <= nreq);
      bus_rdata = (!is_wr && t == 1 + nreq + rv_at) ? rd : 32'hDEAD_BEEF;
      exp_stall = (t < len);
      exp_req   = (t >= 1) && (t <= nreq);
      exp_err   = (t == len) && ferr;
      exp_we    = is_wr;
      exp_addr  = {a[31:2], 2'b00};
      exp_wdata = wd;
      if (t == len && !is_wr) exp_rdata = ferr ? 32'd0 : rd;
    end
    @(negedge clk); #1;
    stalls_seen = stall_cnt;
  endtask

  int s, s2;

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    set_idle_exp(); exp_rdata = '0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    #12;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_outs", {26'd0, stall, err, bus_req, bus_we, |bus_addr, |bus_wdata}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Store, gnt in first REQ cycle: two stalled cycles.
    run_acc(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, -1, '0, 1'b0, s);
    chk("store_stall_len", s, 2);
    idle(1);

    // Load, gnt after 2 REQ cycles, rvalid in 3rd RESP cycle; stray rvalid in REQ.
    run_acc(1'b1, 1'b0, 32'h0000_0024, '0, 2, 2, 32'h1234_5678, 1'b1, s);
    chk("load_stall_len", s, 7);
    chk("load_rdata", rdata, 32'h1234_5678);
    idle(1);

    // Reset in the middle of a RESP phase; late rvalid must be ignored.
    chk_en = 1'b0;
    @(posedge clk); #1; memread = 1'b1; addr = 32'h40;          // IDLE
    @(posedge clk); #1; bus_gnt = 1'b1;                         // REQ
    @(posedge clk); #1; bus_gnt = 1'b0;                         // RESP
    #2; reset = 1'b1; memread = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_outs", {27'd0, stall, err, bus_we, |bus_addr, |bus_wdata}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1; bus_rvalid = 1'b0;
    chk("late_rvalid_rdata", rdata, 32'd0);
    chk("late_rvalid_req", {31'd0, bus_req}, 32'd0);
    exp_rdata = '0; set_idle_exp();
    chk_en = 1'b1;
    idle(1);

    // Zero-wait load to give rdata a non-zero value.
    run_acc(1'b1, 1'b0, 32'h0000_0100, '0, 0, 0, 32'hA5A5_0001, 1'b0, s);
    chk("zw_load_stall", s, 3);

    // Grant never arrives: aborted after 16 REQ cycles.
    run_acc(1'b1, 1'b0, 32'h0000_0200, '0, -1, -1, '0, 1'b0, s);
    chk("timeout_stall", s, 17);
    chk("timeout_rdata", rdata, 32'd0);
    idle(2);

    // Granted load whose data never returns: aborted from RESP.
    run_acc(1'b1, 1'b0, 32'h0000_0300, '0, 0, 0, 32'h0BAD_CAFE, 1'b0, s);
    run_acc(1'b1, 1'b0, 32'h0000_0304, '0, 0, -1, '0, 1'b0, s);
    chk("resp_timeout_stall", s, 17);

    // Store granted on the very last permitted REQ cycle completes cleanly.
    run_acc(1'b0, 1'b1, 32'h0000_0400, 32'h1111_2222, TO - 1, -1, '0, 1'b0, s);
    chk("late_gnt_store_stall", s, 17);

    // memread and memwrite together act as a write; rdata untouched.
    run_acc(1'b1, 1'b0, 32'h0000_0500, '0, 1, 1, 32'h7777_8888, 1'b0, s);
    run_acc(1'b1, 1'b1, 32'h0000_0508, 32'h3333_4444, 0, -1, '0, 1'b0, s);
    chk("rw_as_write_rdata", rdata, 32'h7777_8888);

    // Misaligned load: no bus activity, err in next cycle.
    run_acc(1'b1, 1'b0, 32'h0000_0006, '0, 0, 0, 32'h5555_5555, 1'b0, s);
    chk("misaligned_stall", s, 1);
    chk("misaligned_rdata", rdata, 32'd0);
    idle(1);

    // Back-to-back load then store with zero wait states.
    run_acc(1'b1, 1'b0, 32'h0000_0600, '0, 0, 0, 32'h9999_AAAA, 1'b0, s);
    run_acc(1'b0, 1'b1, 32'h0000_0604, 32'hBBBB_CCCC, 0, -1, '0, 1'b0, s2);
    chk("b2b_stall_pattern", {25'd0, stall_hist}, 32'b1110110);
    chk("b2b_rdata", rdata, 32'h9999_AAAA);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
